// File: rtl/fp_panel_pkg.sv
// fp_panel_pkg: shared types, default widths and counter sizing for the front-panel deposit sequencer.
package fp_panel_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 16;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} fp_dep_state_t;
  function automatic int cnt_w(input int setup_cyc, input int wr_pulse);
    int m;
    m = setup_cyc > wr_pulse ? setup_cyc : wr_pulse;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/fp_deposit_seq_if.sv
// fp_deposit_seq_if: panel-switch side and memory-write side of the deposit sequencer.
interface fp_deposit_seq_if import fp_panel_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              dep_req;
  logic              dep_next_req;
  logic [DATA_W-1:0] data_sw;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wr;
  logic              busy;
  logic              deposit_latch;
  logic              done;
  logic              addr_upd;
  logic [ADDR_W-1:0] addr_next;
  modport master (
    output dep_req, dep_next_req, data_sw, addr_in,
    input  mem_addr, mem_data, mem_wr, busy, deposit_latch, done, addr_upd, addr_next
  );
  modport slave (
    input  dep_req, dep_next_req, data_sw, addr_in,
    output mem_addr, mem_data, mem_wr, busy, deposit_latch, done, addr_upd, addr_next
  );
endinterface

// File: rtl/fp_edge_rise.sv
// fp_edge_rise: one-cycle rising-edge pulse from a debounced level, with selectable reset value
// for the previous sample so a level held through reset release does not fire.
module fp_edge_rise #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) prev <= RST_VAL;
    else          prev <= level;
  assign rise = level & ~prev;
endmodule

// File: rtl/fp_deposit_seq.sv
// fp_deposit_seq: DEPOSIT / DEPOSIT NEXT switch action to timed memory write (setup, strobe, hold).
// DEPOSIT NEXT support is built only when DEPOSIT_NEXT_EN is defined.
module fp_deposit_seq import fp_panel_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int SETUP_CYC = 1,
  parameter int WR_PULSE  = 2
) (
  input logic             clk,
  input logic             reset_n,
  fp_deposit_seq_if.slave bus
);
  localparam int CW = cnt_w(SETUP_CYC, WR_PULSE);
  fp_dep_state_t     state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [DATA_W-1:0] data_q, data_d;
  logic              next_q, next_d;
  logic              dep_rise, next_rise;
  fp_edge_rise #(.RST_VAL(1'b1)) u_dep (
    .clk(clk), .reset_n(reset_n), .level(bus.dep_req), .rise(dep_rise)
  );
`ifdef DEPOSIT_NEXT_EN
  fp_edge_rise #(.RST_VAL(1'b1)) u_next (
    .clk(clk), .reset_n(reset_n), .level(bus.dep_next_req), .rise(next_rise)
  );
  assign addr_inc      = bus.addr_in + ADDR_W'(1);
  assign bus.addr_upd  = state == DONE && next_q;
  assign bus.addr_next = state == DONE ? addr_q : '0;
`else
  logic unused_next;
  assign unused_next   = bus.dep_next_req;
  assign next_rise     = 1'b0;
  assign addr_inc      = bus.addr_in;
  assign bus.addr_upd  = 1'b0;
  assign bus.addr_next = '0;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_d  = addr_q;
    data_d  = data_q;
    next_d  = next_q;
    case (state)
      IDLE:
        // DEPOSIT takes priority when both switches rise together
        if (dep_rise || next_rise) begin
          state_n = SETUP;
          cnt_n   = CW'(SETUP_CYC - 1);
          addr_d  = dep_rise ? bus.addr_in : addr_inc;
          data_d  = bus.data_sw;
          next_d  = !dep_rise;
        end
      SETUP:
        if (cnt == '0) begin
          state_n = STROBE;
          cnt_n   = CW'(WR_PULSE - 1);
        end else cnt_n = cnt - CW'(1);
      STROBE:
        if (cnt == '0) state_n = HOLD;
        else cnt_n = cnt - CW'(1);
      HOLD:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      next_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr_q <= addr_d;
      data_q <= data_d;
      next_q <= next_d;
    end
  assign bus.mem_addr      = addr_q;
  assign bus.mem_data      = data_q;
  assign bus.mem_wr        = state == STROBE;
  assign bus.busy          = state != IDLE;
  assign bus.deposit_latch = state != IDLE;
  assign bus.done          = state == DONE;
endmodule

// File: tb/tb_fp_deposit_seq.sv
// tb_fp_deposit_seq: directed scenarios for the default sequencer and a SETUP_CYC=3/WR_PULSE=1 instance.
module tb_fp_deposit_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  fp_deposit_seq_if #(.DATA_W(8), .ADDR_W(16)) b0 ();
  fp_deposit_seq_if #(.DATA_W(8), .ADDR_W(16)) b1 ();
  fp_deposit_seq u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  fp_deposit_seq #(.SETUP_CYC(3), .WR_PULSE(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic seen;
    reset_n = 1'b0;
    b0.dep_req = 1'b1; b0.dep_next_req = 1'b1; b0.addr_in = 16'h1234; b0.data_sw = 8'h55;
    b1.dep_req = 1'b1; b1.dep_next_req = 1'b1; b1.addr_in = 16'h4321; b1.data_sw = 8'hAA;
    repeat (2) tick();
    vectors++;
    if ({b0.mem_addr, b0.mem_data, b0.mem_wr, b0.busy, b0.deposit_latch, b0.done, b0.addr_upd, b0.addr_next} !== 45'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {b0.mem_addr, b0.mem_data, b0.mem_wr, b0.busy, b0.deposit_latch, b0.done, b0.addr_upd, b0.addr_next});
    end
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (b0.mem_wr || b0.busy || b1.mem_wr || b1.busy) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL held_through_reset: got activity=%b want 0", seen);
    end
  endtask

  task automatic test_deposit();
    logic [5:0] eb, ew, ed;
    eb = 6'b111110; ew = 6'b011000; ed = 6'b000010;
    b0.dep_req = 1'b0; b0.dep_next_req = 1'b0;
    tick();
    b0.addr_in = 16'h0100; b0.data_sw = 8'hA5; b0.dep_req = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      vectors++;
      if ({b0.busy, b0.deposit_latch, b0.mem_wr, b0.done} !== {eb[6-j], eb[6-j], ew[6-j], ed[6-j]}) begin
        miscompares++;
        $display("FAIL dep_trace N+%0d: busy/latch/wr/done got %b want %b", j,
                 {b0.busy, b0.deposit_latch, b0.mem_wr, b0.done}, {eb[6-j], eb[6-j], ew[6-j], ed[6-j]});
      end
      if (j == 1) begin
        vectors++;
        if ({b0.mem_addr, b0.mem_data} !== {16'h0100, 8'hA5}) begin
          miscompares++;
          $display("FAIL dep_capture: got %h want %h", {b0.mem_addr, b0.mem_data}, {16'h0100, 8'hA5});
        end
      end
      if (j == 5) begin
        vectors++;
        if (b0.addr_upd !== 1'b0) begin
          miscompares++;
          $display("FAIL dep_addr_upd: got %b want 0", b0.addr_upd);
        end
      end
    end
    b0.dep_req = 1'b0;
  endtask

  task automatic test_next();
    int wr;
    b0.dep_req = 1'b0; b0.dep_next_req = 1'b0;
    tick();
    b0.addr_in = 16'hFFFF; b0.data_sw = 8'h3C; b0.dep_next_req = 1'b1;
    wr = 0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (b0.mem_wr) wr++;
`ifdef DEPOSIT_NEXT_EN
      if (j == 1) begin
        vectors++;
        if ({b0.mem_addr, b0.mem_data} !== {16'h0000, 8'h3C}) begin
          miscompares++;
          $display("FAIL next_capture: got %h want %h", {b0.mem_addr, b0.mem_data}, {16'h0000, 8'h3C});
        end
      end
      if (j == 5) begin
        vectors++;
        if ({b0.done, b0.addr_upd, b0.addr_next} !== {1'b1, 1'b1, 16'h0000}) begin
          miscompares++;
          $display("FAIL next_done: got %h want %h", {b0.done, b0.addr_upd, b0.addr_next}, {1'b1, 1'b1, 16'h0000});
        end
      end
      if (j == 6) begin
        vectors++;
        if ({b0.addr_upd, b0.busy} !== 2'b00) begin
          miscompares++;
          $display("FAIL next_after: got %b want 00", {b0.addr_upd, b0.busy});
        end
      end
`else
      vectors++;
      if ({b0.busy, b0.addr_upd, b0.addr_next, b0.mem_addr} !== {1'b0, 1'b0, 16'h0000, 16'h0100}) begin
        miscompares++;
        $display("FAIL next_ignored N+%0d: got %h want %h", j, {b0.busy, b0.addr_upd, b0.addr_next, b0.mem_addr},
                 {1'b0, 1'b0, 16'h0000, 16'h0100});
      end
`endif
    end
    vectors++;
`ifdef DEPOSIT_NEXT_EN
    if (wr !== 2) begin
      miscompares++;
      $display("FAIL next_wr_count: got %0d want 2", wr);
    end
`else
    if (wr !== 0) begin
      miscompares++;
      $display("FAIL next_wr_count: got %0d want 0", wr);
    end
`endif
    b0.dep_next_req = 1'b0;
  endtask

  task automatic test_both();
    int wr;
    b0.dep_req = 1'b0; b0.dep_next_req = 1'b0;
    tick();
    b0.addr_in = 16'h0010; b0.data_sw = 8'h77; b0.dep_req = 1'b1; b0.dep_next_req = 1'b1;
    wr = 0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (b0.mem_wr) wr++;
      if (j == 1) begin
        vectors++;
        if ({b0.mem_addr, b0.mem_data} !== {16'h0010, 8'h77}) begin
          miscompares++;
          $display("FAIL both_capture: got %h want %h", {b0.mem_addr, b0.mem_data}, {16'h0010, 8'h77});
        end
      end
      if (j == 5) begin
        vectors++;
        if ({b0.done, b0.addr_upd} !== 2'b10) begin
          miscompares++;
          $display("FAIL both_done: done/addr_upd got %b want 10", {b0.done, b0.addr_upd});
        end
      end
    end
    vectors++;
    if (wr !== 2) begin
      miscompares++;
      $display("FAIL both_wr_count: got %0d want 2", wr);
    end
    b0.dep_req = 1'b0; b0.dep_next_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] eb, ew, ed;
    logic [23:0] exp_ad;
    eb = 12'b111110111110; ew = 12'b011000011000; ed = 12'b000010000010;
    b0.dep_req = 1'b0;
    tick();
    b0.addr_in = 16'h0200; b0.data_sw = 8'h11; b0.dep_req = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      exp_ad = j <= 6 ? {16'h0200, 8'h11} : {16'h0300, 8'h99};
      vectors++;
      if ({b0.busy, b0.mem_wr, b0.done} !== {eb[12-j], ew[12-j], ed[12-j]}) begin
        miscompares++;
        $display("FAIL b2b_trace N+%0d: busy/wr/done got %b want %b", j,
                 {b0.busy, b0.mem_wr, b0.done}, {eb[12-j], ew[12-j], ed[12-j]});
      end
      vectors++;
      if ({b0.mem_addr, b0.mem_data} !== exp_ad) begin
        miscompares++;
        $display("FAIL b2b_addr_data N+%0d: got %h want %h", j, {b0.mem_addr, b0.mem_data}, exp_ad);
      end
      if (j == 1) b0.dep_req = 1'b0;
      if (j == 2) b0.data_sw = 8'h99;
      if (j == 3) begin b0.dep_req = 1'b1; b0.addr_in = 16'h0300; end
      if (j == 5) b0.dep_req = 1'b0;
      if (j == 6) b0.dep_req = 1'b1;
    end
    b0.dep_req = 1'b0;
  endtask

  task automatic test_slow();
    logic [6:0] eb, ew, ed;
    logic seen;
    eb = 7'b1111110; ew = 7'b0001000; ed = 7'b0000010;
    b1.dep_req = 1'b0; b1.dep_next_req = 1'b0;
    tick();
    b1.addr_in = 16'h0ABC; b1.data_sw = 8'h5A; b1.dep_req = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick();
      vectors++;
      if ({b1.busy, b1.mem_wr, b1.done, b1.addr_upd} !== {eb[7-j], ew[7-j], ed[7-j], 1'b0}) begin
        miscompares++;
        $display("FAIL slow_trace N+%0d: busy/wr/done/upd got %b want %b", j,
                 {b1.busy, b1.mem_wr, b1.done, b1.addr_upd}, {eb[7-j], ew[7-j], ed[7-j], 1'b0});
      end
      if (j == 1) begin
        vectors++;
        if ({b1.mem_addr, b1.mem_data} !== {16'h0ABC, 8'h5A}) begin
          miscompares++;
          $display("FAIL slow_capture: got %h want %h", {b1.mem_addr, b1.mem_data}, {16'h0ABC, 8'h5A});
        end
      end
    end
    b1.dep_req = 1'b0;
`ifndef DEPOSIT_NEXT_EN
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      b1.dep_next_req = j[0];
      tick();
      if (b1.busy || b1.mem_wr || b1.addr_upd) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL slow_next_ignored: got activity=%b want 0", seen);
    end
    b1.dep_next_req = 1'b0;
`else
    seen = 1'b0;
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    logic seen;
    b0.dep_req = 1'b0;
    tick();
    b0.addr_in = 16'h0400; b0.data_sw = 8'hC3; b0.dep_req = 1'b1;
    repeat (2) tick();
    vectors++;
    if (b0.mem_wr !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_strobe: mem_wr got %b want 1", b0.mem_wr);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({b0.mem_addr, b0.mem_data, b0.mem_wr, b0.busy, b0.deposit_latch, b0.done, b0.addr_upd, b0.addr_next} !== 45'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h want 0", {b0.mem_addr, b0.mem_data, b0.mem_wr, b0.busy, b0.deposit_latch, b0.done, b0.addr_upd, b0.addr_next});
    end
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (b0.mem_wr || b0.busy) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_after_release: got activity=%b want 0", seen);
    end
    b0.dep_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_deposit();
    test_next();
    test_both();
    test_back_to_back();
    test_slow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fp_deposit_seq.md
# fp_deposit_seq

Parametrised front-panel deposit sequencer for the Altair console. It turns a DEPOSIT or DEPOSIT NEXT switch action into a timed memory write cycle: address and data setup, then a write strobe of programmable width, then hold. On DEPOSIT NEXT it first advances the address and reports the new address back so the panel address register can follow. It sits between the debounced front-panel switches and the memory write mux, and replaces the fixed 8-bit single-shot deposit latch.

## Interface
- DATA_W, 8: data switch / memory data width
- ADDR_W, 16: memory address width
- SETUP_CYC, 1: cycles address and data are held stable before the strobe; must be ≥1
- WR_PULSE, 2: mem_wr high time in cycles; must be ≥1

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- dep_req  in  1  DEPOSIT switch level (debounced); acts on its rising edge
- dep_next_req  in  1  DEPOSIT NEXT switch level (debounced); acts on its rising edge
- data_sw  in  DATA_W  data switches SA0..SA(DATA_W-1)
- addr_in  in  ADDR_W  current panel address
- mem_addr  out  ADDR_W  write address, registered
- mem_data  out  DATA_W  write data, registered
- mem_wr  out  1  write strobe
- busy  out  1  high from the cycle after acceptance through DONE
- deposit_latch  out  1  identical to busy; kept for existing panel LED and mux logic
- done  out  1  one-cycle completion pulse
- addr_upd  out  1  one-cycle pulse in DONE, DEPOSIT NEXT only
- addr_next  out  ADDR_W  incremented address; valid while addr_upd is high

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- Edge detection: prev_dep and prev_next reset to 1, so a switch held through reset release does not fire.
- IDLE, dep rise:
  - capture mem_addr←addr_in and mem_data←data_sw
  - clear the next flag
  - load the counter with SETUP_CYC-1
  - go to SETUP
- IDLE, next rise with no dep rise:
  - capture mem_addr←addr_in+1, modulo 2^ADDR_W (all-ones wraps to 0)
  - capture mem_data←data_sw
  - set the next flag
  - go to SETUP
- Both edges in the same cycle: DEPOSIT wins and DEPOSIT NEXT is dropped.
- SETUP: count down. At 0, load WR_PULSE-1 and go to STROBE.
- STROBE: mem_wr=1. At count 0, go to HOLD.
- HOLD: mem_wr=0, address and data unchanged. Go to DONE.
- DONE:
  - done=1
  - addr_upd equals the next flag
  - addr_next equals mem_addr
  - go to IDLE
- Rising edges that arrive while not in IDLE are ignored, not queued. Edge registers still track the inputs every cycle.
- mem_addr and mem_data change only at acceptance.
- data_sw and addr_in changes after acceptance have no effect.
- mem_wr, busy and done decode from registered state only (Moore outputs).
- Reset values: state IDLE, counter 0, and mem_addr, mem_data, mem_wr, busy, deposit_latch, done, addr_upd, addr_next all 0.
- Reset mid-operation: every output goes to its reset value asynchronously. mem_wr drops immediately; no partial write is retried.

## Timing
- Request sampled high (previous sample low) at edge N:
  - SETUP during cycles N+1 to N+SETUP_CYC
  - mem_wr high during N+SETUP_CYC+1 to N+SETUP_CYC+WR_PULSE
  - HOLD in the next cycle
  - done (and addr_upd) in cycle N+SETUP_CYC+WR_PULSE+2
  - IDLE from the cycle after that
- Defaults: busy N+1 to N+5, mem_wr N+2 to N+3, done at N+5. Earliest next acceptance is at edge N+6.
- mem_addr and mem_data are stable from N+1 through DONE, covering setup and hold around every strobe.

## Configuration
- DEPOSIT_NEXT_EN defined: DEPOSIT NEXT behaves as above.
- DEPOSIT_NEXT_EN undefined:
  - dep_next_req is ignored and its edge register is removed
  - addr_upd and addr_next are tied to 0
  - the incrementer is not built
  - ports remain present in both builds

## Structure
- Package fp_panel_pkg:
  - state enum fp_dep_state_t
  - default DATA_W and ADDR_W constants
  - counter width function: $clog2 of the maximum of SETUP_CYC and WR_PULSE, minimum 1
- Sub-module fp_edge_rise:
  - parametrised reset value of the previous-sample register
  - outputs a one-cycle rise pulse
  - one instance per switch

## Test plan
- Reset release with dep_req already held at 1 → no mem_wr. Drop it, then raise it with addr_in=0x0100, data_sw=0xA5 → mem_addr=0x0100, mem_data=0xA5, mem_wr high 2 cycles, done at N+5, addr_upd=0.
- DEPOSIT NEXT with addr_in=0xFFFF, data_sw=0x3C → write at 0x0000; addr_upd=1 with addr_next=0x0000 in DONE.
- dep_req and dep_next_req rise in the same cycle, addr_in=0x0010 → single write at 0x0010, addr_upd=0.
- Second dep_req rise at N+3, and data_sw changed at N+2 → no second write, mem_data stays at the first value. A rise at N+6 is accepted.
- reset_n low during STROBE → mem_wr, busy and all other outputs 0 immediately. After release, idle with no spurious write.
- SETUP_CYC=3, WR_PULSE=1, built without DEPOSIT_NEXT_EN → mem_wr high only at N+4, done at N+6. dep_next_req pulses produce no activity.
